multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencer for the RV32I core. Replaces the single-cycle combinational decode with a Moore state machine that spreads each instruction over 3–5 cycles. It arbitrates one unified instruction/data memory port between instruction fetch and load/store through a req/ready handshake. It drives the datapath enables and muxes, including IR, PC, register file, ALU operand selects, immediate format and ALU op class.

## Interface
Parameters:
- CNT_W, 32, width of performance counters (used only with MC_PERF_CNT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  IR[6:0], valid from DECODE onward
- branch_taken  in  1  datapath comparator result for current branch funct3
- mem_ready  in  1  memory accepts/completes the access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, qualified by mem_req
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  latch IR and old_pc
- pc_write  out  1  PC register enable
- pc_src  out  1  0 = ALU result, 1 = ALUOut
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR
- alu_src_a  out  2  00 = PC, 01 = A, 10 = old_pc
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = immediate
- imm_sel  out  3  000 = I-load, 001 = S, 010 = B, 011 = I-arith
- alu_op  out  2  00 = add, 01 = branch compare, 10 = R funct, 11 = I funct
- illegal  out  1  sticky illegal-opcode flag
- cycle_cnt, instret_cnt  out  CNT_W  present only with MC_PERF_CNT_EN

Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.

## Operation
- States: BOOT, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, HALT. All outputs are decoded from state (Moore), except FETCH/BRANCH strobes gated by inputs as noted.
- Any output not listed for a state is 0.
- **BOOT:** all outputs 0. Go to FETCH.
- **FETCH:**
  - mem_req=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - Hold until mem_ready=1. In that cycle ir_write=1, pc_write=1, pc_src=0. Go to DECODE.
- **DECODE:** alu_src_a=10, alu_src_b=10, imm_sel=010, alu_op=00, which precomputes the branch target into ALUOut. Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - any other opcode → HALT
- **EXEC_R:** alu_src_a=01, alu_src_b=00, alu_op=10. Go to WB_ALU.
- **EXEC_I:** alu_src_a=01, alu_src_b=10, imm_sel=011, alu_op=11. Go to WB_ALU.
- **MEM_ADDR:** alu_src_a=01, alu_src_b=10, alu_op=00. imm_sel=000 for load, 001 for store. Go to MEM_RD for load, MEM_WR for store.
- **MEM_RD:** mem_req=1, iord=1. Hold until mem_ready. Go to WB_MEM.
- **MEM_WR:** mem_req=1, mem_we=1, iord=1. Hold until mem_ready. Go to FETCH.
- **WB_ALU:** reg_write=1, mem_to_reg=0. Go to FETCH.
- **WB_MEM:** reg_write=1, mem_to_reg=1. Go to FETCH.
- **BRANCH:** alu_src_a=01, alu_src_b=00, alu_op=01, pc_src=1, pc_write=branch_taken. Go to FETCH.
- **HALT:** illegal=1, all other outputs 0. Absorbing; only rst exits.

## Timing
- Reset: state=BOOT and every output 0, asynchronously while rst=1. Counters clear to 0.
- Handshake:
  - A transfer completes on any rising edge with mem_req & mem_ready.
  - mem_req, mem_we and iord stay stable from assertion until completion.
  - mem_ready while mem_req=0 is ignored.
  - mem_req drops in the cycle after completion, except FETCH→DECODE, where it is low in DECODE anyway.
- Latency with zero wait states (cycles from entering FETCH to re-entering FETCH):
  - R, I-arith, store: 4
  - load: 5
  - branch: 3
  - Each mem_ready-low cycle in FETCH, MEM_RD or MEM_WR adds 1.
- rst asserted mid-access drops mem_req and mem_we immediately. No partial write is committed by this block.
- The first FETCH is the second cycle after rst deasserts.

## Configuration
- MC_PERF_CNT_EN defined:
  - cycle_cnt increments every cycle outside BOOT and HALT.
  - instret_cnt increments on each transition into FETCH from WB_ALU, WB_MEM, MEM_WR or BRANCH.
  - Both counters wrap modulo 2^CNT_W.
- Not defined: counter ports and registers are absent.

## Structure
- Package multicycle_pkg holds:
  - state enum ctrl_state_e (4-bit)
  - opcode localparams OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH
  - encodings for alu_src_a/b, imm_sel and alu_op
- No sub-module. The next-state/output decode and the optional counters stay in one file.

## Test plan
- R-type, mem_ready tied 1 → states FETCH, DECODE, EXEC_R, WB_ALU. reg_write=1 exactly once, on cycle 4.
- Load with mem_ready low 2 cycles in MEM_RD → 7 cycles total. mem_req/iord=1 held stable for 3 cycles, then WB_MEM with mem_to_reg=1.
- Store → mem_we=1 only in MEM_WR, reg_write never 1, 4 cycles.
- Branch:
  - branch_taken=1 → pc_write=1 with pc_src=1 in BRANCH.
  - branch_taken=0 → pc_write=0 in BRANCH.
- opcode 7'b1111111 → HALT. illegal=1 stays set for 20+ cycles, mem_req stays 0, and rst recovers to BOOT.
- rst pulsed during MEM_WR wait → mem_req and mem_we fall the same cycle. With MC_PERF_CNT_EN: 3 R-types at zero wait give instret_cnt=3 and cycle_cnt=12.

Source files
------------

// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared state, opcode and datapath-select encodings for the multi-cycle RV32I sequencer
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_HALT
    } ctrl_state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_REG    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [2:0] IMM_LOAD   = 3'b000;
    localparam logic [2:0] IMM_STORE  = 3'b001;
    localparam logic [2:0] IMM_BRANCH = 3'b010;
    localparam logic [2:0] IMM_ARITH  = 3'b011;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_RFUNCT = 2'b10;
    localparam logic [1:0] ALU_IFUNCT = 2'b11;

    // Moore outputs that depend only on the state (plus the latched opcode)
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       pc_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       illegal;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_sel;
        logic [1:0] alu_op;
    } ctrl_out_t;

    // Output decode for a given state; op only matters for the load/store immediate format
    function automatic ctrl_out_t state_outs(input ctrl_state_e s, input logic [6:0] op);
        ctrl_out_t o;
        o = '0;
        case (s)
            S_FETCH: begin
                o.mem_req   = 1'b1;
                o.alu_src_a = SRC_A_PC;
                o.alu_src_b = SRC_B_FOUR;
                o.alu_op    = ALU_ADD;
            end
            S_DECODE: begin
                o.alu_src_a = SRC_A_OLD_PC;
                o.alu_src_b = SRC_B_IMM;
                o.imm_sel   = IMM_BRANCH;
                o.alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
                o.alu_src_a = SRC_A_REG;
                o.alu_src_b = SRC_B_REG;
                o.alu_op    = ALU_RFUNCT;
            end
            S_EXEC_I: begin
                o.alu_src_a = SRC_A_REG;
                o.alu_src_b = SRC_B_IMM;
                o.imm_sel   = IMM_ARITH;
                o.alu_op    = ALU_IFUNCT;
            end
            S_MEM_ADDR: begin
                o.alu_src_a = SRC_A_REG;
                o.alu_src_b = SRC_B_IMM;
                o.imm_sel   = (op == OP_STORE) ? IMM_STORE : IMM_LOAD;
                o.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                o.mem_req = 1'b1;
                o.iord    = 1'b1;
            end
            S_MEM_WR: begin
                o.mem_req = 1'b1;
                o.mem_we  = 1'b1;
                o.iord    = 1'b1;
            end
            S_WB_ALU: o.reg_write = 1'b1;
            S_WB_MEM: begin
                o.reg_write  = 1'b1;
                o.mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                o.alu_src_a = SRC_A_REG;
                o.alu_src_b = SRC_B_REG;
                o.alu_op    = ALU_BRANCH;
                o.pc_src    = 1'b1;
            end
            S_HALT: o.illegal = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore sequencer for a multi-cycle RV32I core; optional perf counters under MC_PERF_CNT_EN
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_sel,
    output logic [1:0] alu_op,
    output logic       illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    ctrl_state_e state, state_d;
    ctrl_out_t   outs;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    // Next state: memory states wait on mem_ready, DECODE dispatches on the opcode
    always_comb begin
        state_d = state;
        case (state)
            S_BOOT:     state_d = S_FETCH;
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   state_d = (opcode == OP_R)                           ? S_EXEC_R   :
                                  (opcode == OP_IMM)                         ? S_EXEC_I   :
                                  (opcode == OP_LOAD || opcode == OP_STORE)  ? S_MEM_ADDR :
                                  (opcode == OP_BRANCH)                      ? S_BRANCH   : S_HALT;
            S_EXEC_R:   state_d = S_WB_ALU;
            S_EXEC_I:   state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_WB_ALU:   state_d = S_FETCH;
            S_WB_MEM:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_BOOT;
        endcase
    end

    // State and registered Moore outputs; async reset kills mem_req/mem_we at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_BOOT;
            outs  <= '0;
        end else begin
            state <= state_d;
            outs  <= state_outs(state_d, opcode);
        end
    end

    assign mem_req    = outs.mem_req;
    assign mem_we     = outs.mem_we;
    assign iord       = outs.iord;
    assign pc_src     = outs.pc_src;
    assign reg_write  = outs.reg_write;
    assign mem_to_reg = outs.mem_to_reg;
    assign alu_src_a  = outs.alu_src_a;
    assign alu_src_b  = outs.alu_src_b;
    assign imm_sel    = outs.imm_sel;
    assign alu_op     = outs.alu_op;
    assign illegal    = outs.illegal;

    // Strobes that fire in the completing fetch cycle or on a taken branch
    assign ir_write = (state == S_FETCH) && mem_ready;
    assign pc_write = ((state == S_FETCH) && mem_ready) || ((state == S_BRANCH) && branch_taken);

`ifdef MC_PERF_CNT_EN
    logic retire;

    assign retire = (state_d == S_FETCH) &&
                    (state == S_WB_ALU || state == S_WB_MEM || state == S_MEM_WR || state == S_BRANCH);

    // Active-cycle and retired-instruction counters, free-running with wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != S_BOOT && state != S_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire) instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream checked against a per-instruction cycle-trace model
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_sel;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int exp_cyc = 0;
    int exp_ret = 0;

    logic [17:0] exp_q[$];
    bit          rdy_q[$];
    bit          bt_q[$];

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_sel(imm_sel), .alu_op(alu_op), .illegal(illegal)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg, illegal, a, b, imm, op}
    function automatic logic [17:0] obs();
        return {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg, illegal,
                alu_src_a, alu_src_b, imm_sel, alu_op};
    endfunction

    function automatic logic [17:0] rec(input logic [8:0] f, input logic [1:0] a, input logic [1:0] b,
                                        input logic [2:0] imm, input logic [1:0] op);
        return {f, a, b, imm, op};
    endfunction

    function automatic logic [6:0] pick_op(input int cls);
        logic [6:0] o;
        case (cls)
            0: o = 7'b0110011;
            1: o = 7'b0010011;
            2: o = 7'b0000011;
            3: o = 7'b0100011;
            4: o = 7'b1100011;
            default: begin
                o = 7'($urandom);
                while (o == 7'b0110011 || o == 7'b0010011 || o == 7'b0000011 || o == 7'b0100011 || o == 7'b1100011)
                    o = 7'($urandom);
            end
        endcase
        return o;
    endfunction

    task automatic push(input logic [17:0] e, input bit r, input bit b);
        exp_q.push_back(e);
        rdy_q.push_back(r);
        bt_q.push_back(b);
    endtask

    task automatic push_idle(input logic [17:0] e);
        push(e, 1'($urandom), 1'($urandom));
    endtask

    task automatic push_fetch(input int w);
        for (int i = 0; i < w; i++) push(rec(9'b100_000_000, 2'b00, 2'b01, 3'b000, 2'b00), 1'b0, 1'($urandom));
        push(rec(9'b100_110_000, 2'b00, 2'b01, 3'b000, 2'b00), 1'b1, 1'($urandom));
        push_idle(rec(9'b000_000_000, 2'b10, 2'b10, 3'b010, 2'b00));
    endtask

    task automatic push_mem(input logic [8:0] f, input int w);
        for (int i = 0; i < w; i++) push(rec(f, 2'b00, 2'b00, 3'b000, 2'b00), 1'b0, 1'($urandom));
        push(rec(f, 2'b00, 2'b00, 3'b000, 2'b00), 1'b1, 1'($urandom));
    endtask

    task automatic run_seq();
        bit first;
        first = 1'b1;
        while (exp_q.size() > 0) begin
            logic [17:0] e;
            e = exp_q.pop_front();
            @(negedge clk);
            mem_ready    = rdy_q.pop_front();
            branch_taken = bt_q.pop_front();
            #1;
`ifdef MC_PERF_CNT_EN
            if (first) begin
                check("cycle_cnt", cycle_cnt, exp_cyc);
                check("instret_cnt", instret_cnt, exp_ret);
            end
`endif
            check("outputs", {14'd0, obs()}, {14'd0, e});
            if (!e[9]) exp_cyc++;
            first = 1'b0;
        end
    endtask

    // One instruction of class cls (0 R, 1 I, 2 load, 3 store, 4 branch, 5 illegal) with up to maxw waits per access
    task automatic do_instr(input int cls, input int maxw, input logic [6:0] force_op = 7'd0);
        bit taken;
        taken  = 1'($urandom);
        opcode = (force_op != 7'd0) ? force_op : pick_op(cls);
        push_fetch($urandom_range(0, maxw));
        case (cls)
            0: begin
                push_idle(rec(9'b0, 2'b01, 2'b00, 3'b000, 2'b10));
                push_idle(rec(9'b000_000_100, 2'b00, 2'b00, 3'b000, 2'b00));
            end
            1: begin
                push_idle(rec(9'b0, 2'b01, 2'b10, 3'b011, 2'b11));
                push_idle(rec(9'b000_000_100, 2'b00, 2'b00, 3'b000, 2'b00));
            end
            2: begin
                push_idle(rec(9'b0, 2'b01, 2'b10, 3'b000, 2'b00));
                push_mem(9'b101_000_000, $urandom_range(0, maxw));
                push_idle(rec(9'b000_000_110, 2'b00, 2'b00, 3'b000, 2'b00));
            end
            3: begin
                push_idle(rec(9'b0, 2'b01, 2'b10, 3'b001, 2'b00));
                push_mem(9'b111_000_000, $urandom_range(0, maxw));
            end
            4: push(rec({4'b0000, taken, 4'b1000}, 2'b01, 2'b00, 3'b000, 2'b01), 1'($urandom), taken);
            default: for (int i = 0; i < 25; i++) push_idle(rec(9'b000_000_001, 2'b00, 2'b00, 3'b000, 2'b00));
        endcase
        run_seq();
        if (cls != 5) exp_ret++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("reset_outs", {14'd0, obs()}, 32'd0);
`ifdef MC_PERF_CNT_EN
        check("reset_cycle_cnt", cycle_cnt, 32'd0);
        check("reset_instret_cnt", instret_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("boot_outs", {14'd0, obs()}, 32'd0);
        exp_cyc = 0;
        exp_ret = 0;
    endtask

    // Store stalled in MEM_WR, then rst lands before the write completes
    task automatic reset_in_store();
        opcode = 7'b0100011;
        push_fetch(0);
        push_idle(rec(9'b0, 2'b01, 2'b10, 3'b001, 2'b00));
        push(rec(9'b111_000_000, 2'b00, 2'b00, 3'b000, 2'b00), 1'b0, 1'b0);
        push(rec(9'b111_000_000, 2'b00, 2'b00, 3'b000, 2'b00), 1'b0, 1'b0);
        run_seq();
        #1 rst = 1'b1;
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("boot_after_store_rst", {14'd0, obs()}, 32'd0);
        exp_cyc = 0;
        exp_ret = 0;
    endtask

    initial begin
        rst          = 1'b1;
        opcode       = 7'd0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) do_instr(0, 0);
`ifdef MC_PERF_CNT_EN
        #5;
        check("three_r_cycle_cnt", cycle_cnt, 32'd12);
        check("three_r_instret_cnt", instret_cnt, 32'd3);
`endif
        do_instr(2, 0);
        for (int i = 0; i < 60; i++) do_instr($urandom_range(0, 4), 3);
        reset_in_store();
        for (int i = 0; i < 10; i++) do_instr($urandom_range(0, 4), 2);
        do_instr(5, 2, 7'b1111111);
        do_reset();
        do_instr(0, 1);
        do_instr(5, 1);
        do_reset();
        do_instr(4, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
